// File: rtl/cpu_pkg.sv
// Shared CPU constants, writeback source encodings and the queued-write record
// used by the register-file writeback path.
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 3;
  localparam int NREGS     = 8;
  localparam int WB_QDEPTH = 4;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_ID  = 1'b1;

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO of deferred register writes: up to two pushes and one pop per
// cycle, with per-slot valid/address vectors so the pending bitmap can be built.
module wb_queue
  import cpu_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     push_cnt,
  input  wb_entry_t                      push_a,
  input  wb_entry_t                      push_b,
  input  logic                           pop,
  output wb_entry_t                      head,
  output logic [CNT_W-1:0]               count,
  output logic [QDEPTH-1:0]              entry_valid,
  output logic [QDEPTH-1:0][ADDR_W-1:0]  entry_addr
);

  wb_entry_t        mem [QDEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop clears the head slot; pushes set tail slots. They never collide
  // because the arbiter only accepts while at least two slots are free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (pop) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= wrap_inc(head_ptr);
      end
      if (push_cnt != 2'd0)
        entry_valid[tail_ptr] <= 1'b1;
      if (push_cnt == 2'd2)
        entry_valid[wrap_inc(tail_ptr)] <= 1'b1;
      case (push_cnt)
        2'd1:    tail_ptr <= wrap_inc(tail_ptr);
        2'd2:    tail_ptr <= wrap_inc(wrap_inc(tail_ptr));
        default: tail_ptr <= tail_ptr;
      endcase
      count <= count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0)
      mem[tail_ptr] <= push_a;
    if (push_cnt == 2'd2)
      mem[wrap_inc(tail_ptr)] <= push_b;
  end

  always_comb begin
    head = mem[head_ptr];
    for (int i = 0; i < QDEPTH; i++)
      entry_addr[i] = mem[i].addr;
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and ID results onto the single register-file write port, issuing
// one write per cycle in age order and publishing a per-register pending map.
module rf_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8,
  parameter int QDEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_W-1:0]            alu_addr,
  input  logic [DATA_W-1:0]            alu_data,
  input  logic                         id_valid,
  output logic                         id_ready,
  input  logic [ADDR_W-1:0]            id_addr,
  input  logic [DATA_W-1:0]            id_data,
  output logic                         w_enable,
  output logic                         w_select,
  output logic [ADDR_W-1:0]            w_addr,
  output logic [DATA_W-1:0]            w_alu,
  output logic [DATA_W-1:0]            w_id,
  output logic [NREGS-1:0]             pending,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(QDEPTH + 1);

  wb_entry_t                      alu_entry;
  wb_entry_t                      id_entry;
  wb_entry_t                      head;
  wb_entry_t                      issue;
  wb_entry_t                      push_a;
  wb_entry_t                      push_b;
  logic [1:0]                     push_cnt;
  logic                           pop;
  logic                           issue_valid;
  logic                           ready;
  logic                           alu_fire;
  logic                           id_fire;
  logic [QDEPTH-1:0]              entry_valid;
  logic [QDEPTH-1:0][ADDR_W-1:0]  entry_addr;

  // Two free slots guarantee both same-cycle results fit, so ready never
  // needs to look at valid.
  assign ready     = (q_count <= CNT_W'(QDEPTH - 2));
  assign alu_ready = ready;
  assign id_ready  = ready;
  assign alu_fire  = alu_valid & ready;
  assign id_fire   = id_valid & ready;

  assign alu_entry = '{sel: WB_SRC_ALU, addr: alu_addr, data: alu_data};
  assign id_entry  = '{sel: WB_SRC_ID,  addr: id_addr,  data: id_data};

  // Oldest candidate issues (queue head, then ALU, then ID); the rest append.
  always_comb begin
    push_cnt    = 2'd0;
    push_a      = alu_entry;
    push_b      = id_entry;
    pop         = 1'b0;
    issue_valid = 1'b0;
    issue       = head;
    if (q_count != '0) begin
      pop         = 1'b1;
      issue_valid = 1'b1;
      if (alu_fire && id_fire) begin
        push_cnt = 2'd2;
      end else if (alu_fire) begin
        push_cnt = 2'd1;
      end else if (id_fire) begin
        push_cnt = 2'd1;
        push_a   = id_entry;
      end
    end else if (alu_fire) begin
      issue_valid = 1'b1;
      issue       = alu_entry;
      if (id_fire) begin
        push_cnt = 2'd1;
        push_a   = id_entry;
      end
    end else if (id_fire) begin
      issue_valid = 1'b1;
      issue       = id_entry;
    end
  end

  wb_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_cnt    (push_cnt),
    .push_a      (push_a),
    .push_b      (push_b),
    .pop         (pop),
    .head        (head),
    .count       (q_count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Idle cycles zero both data buses but keep address and select stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_enable <= 1'b0;
      w_select <= WB_SRC_ALU;
      w_addr   <= '0;
      w_alu    <= '0;
      w_id     <= '0;
    end else if (issue_valid) begin
      w_enable <= 1'b1;
      w_select <= issue.sel;
      w_addr   <= issue.addr;
      w_alu    <= (issue.sel == WB_SRC_ALU) ? issue.data : '0;
      w_id     <= (issue.sel == WB_SRC_ID)  ? issue.data : '0;
    end else begin
      w_enable <= 1'b0;
      w_alu    <= '0;
      w_id     <= '0;
    end
  end

  always_comb begin
    pending = '0;
    if (w_enable)
      pending[w_addr] = 1'b1;
    for (int i = 0; i < QDEPTH; i++)
      if (entry_valid[i])
        pending[entry_addr[i]] = 1'b1;
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized bench for rf_writeback_arbiter, compared against an in-order
// queue model of outstanding writes plus a bench-side register file.
module tb_rf_writeback_arbiter;

  localparam int QDEPTH = 4;

  typedef struct packed {
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, id_valid;
  logic        alu_ready, id_ready;
  logic [2:0]  alu_addr, id_addr;
  logic [31:0] alu_data, id_data;
  logic        w_enable, w_select;
  logic [2:0]  w_addr;
  logic [31:0] w_alu, w_id;
  logic [7:0]  pending;
  logic [2:0]  q_count;

  logic [31:0] rf [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: writes accepted but not yet on the port, plus the write on the port.
  wr_t         waitq [$];
  logic        exp_en, exp_sel;
  logic [2:0]  exp_addr;
  logic [31:0] exp_alu, exp_id;

  rf_writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_addr(id_addr), .id_data(id_data),
    .w_enable(w_enable), .w_select(w_select), .w_addr(w_addr),
    .w_alu(w_alu), .w_id(w_id), .pending(pending), .q_count(q_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (w_enable) rf[w_addr] <= w_select ? w_id : w_alu;

  function automatic logic model_ready();
    return waitq.size() <= QDEPTH - 2;
  endfunction

  function automatic logic [7:0] exp_pend();
    logic [7:0] p = '0;
    if (exp_en) p[exp_addr] = 1'b1;
    foreach (waitq[i]) p[waitq[i].addr] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    waitq.delete();
    exp_en = 0; exp_sel = 0; exp_addr = '0; exp_alu = '0; exp_id = '0;
  endtask

  task automatic tick(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                      input logic iv, input logic [2:0] ia, input logic [31:0] idd,
                      output logic acc_a, output logic acc_i);
    wr_t w;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    id_valid  = iv; id_addr  = ia; id_data  = idd;
    acc_a = av && model_ready();
    acc_i = iv && model_ready();
    @(posedge clk);
    if (acc_a) waitq.push_back({1'b0, aa, ad});
    if (acc_i) waitq.push_back({1'b1, ia, idd});
    if (waitq.size() > 0) begin
      w = waitq.pop_front();
      exp_en = 1; exp_sel = w.sel; exp_addr = w.addr;
      exp_alu = w.sel ? 32'h0 : w.data;
      exp_id  = w.sel ? w.data : 32'h0;
    end else begin
      exp_en = 0; exp_alu = '0; exp_id = '0;
    end
    #1;
    alu_valid = 0; id_valid = 0;
  endtask

  task automatic idle();
    logic a, b;
    tick(0, 3'd0, 32'h0, 0, 3'd0, 32'h0, a, b);
  endtask

  task automatic test_reset();
    rst_n = 0; alu_valid = 0; id_valid = 0;
    alu_addr = '0; id_addr = '0; alu_data = '0; id_data = '0;
    #3;
    n_checks++;
    if ({w_enable, w_select, w_addr, w_alu, w_id, pending, q_count} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got en=%b sel=%b addr=%0d alu=%h id=%h pend=%h q=%0d, expected all zero",
               w_enable, w_select, w_addr, w_alu, w_id, pending, q_count);
    end
    @(posedge clk); #1;
    n_checks++;
    if (w_enable !== 1'b0 || alu_ready !== 1'b1 || id_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got en=%b ready=%b/%b, expected 0 1/1", w_enable, alu_ready, id_ready);
    end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_single_alu();
    logic a, b;
    tick(1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'h0, a, b);
    n_checks++;
    if ({w_enable, w_select, w_addr, w_alu, w_id} !== {1'b1, 1'b0, 3'd3, 32'hDEADBEEF, 32'h0}
        || pending !== 8'b0000_1000) begin
      n_fail++;
      $display("[TB] FAIL single_issue: got en=%b sel=%b addr=%0d alu=%h id=%h pend=%b, expected 1 0 3 deadbeef 0 00001000",
               w_enable, w_select, w_addr, w_alu, w_id, pending);
    end
    idle();
    n_checks++;
    if (w_enable !== 1'b0 || pending !== 8'h00 || w_alu !== 32'h0 || w_addr !== 3'd3) begin
      n_fail++;
      $display("[TB] FAIL single_idle: got en=%b pend=%b alu=%h addr=%0d, expected 0 0 0 3",
               w_enable, pending, w_alu, w_addr);
    end
  endtask

  task automatic test_same_cycle();
    logic a, b;
    tick(1, 3'd1, 32'hA, 1, 3'd1, 32'hB, a, b);
    n_checks++;
    if ({w_enable, w_select, w_addr, w_alu, w_id} !== {1'b1, 1'b0, 3'd1, 32'hA, 32'h0}
        || pending !== 8'h02 || q_count !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL same_cycle_alu: got en=%b sel=%b addr=%0d alu=%h id=%h pend=%b q=%0d",
               w_enable, w_select, w_addr, w_alu, w_id, pending, q_count);
    end
    idle();
    n_checks++;
    if ({w_enable, w_select, w_addr, w_alu, w_id} !== {1'b1, 1'b1, 3'd1, 32'h0, 32'hB}
        || pending !== 8'h02 || q_count !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL same_cycle_id: got en=%b sel=%b addr=%0d alu=%h id=%h pend=%b q=%0d",
               w_enable, w_select, w_addr, w_alu, w_id, pending, q_count);
    end
    idle();
    n_checks++;
    if (rf[1] !== 32'hB || pending !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL same_cycle_rf: got r1=%h pend=%b, expected 0000000b 0", rf[1], pending);
    end
  endtask

  task automatic test_back_to_back();
    logic a, b;
    wr_t sent [$];
    wr_t seen [$];
    logic [31:0] ad, idd;
    logic [2:0]  aa, ia;
    int exp_q [4] = '{1, 2, 3, 2};
    for (int c = 0; c < 4; c++) begin
      aa = 3'($urandom); ia = 3'($urandom); ad = $urandom; idd = $urandom;
      tick(1, aa, ad, 1, ia, idd, a, b);
      if (a) sent.push_back({1'b0, aa, ad});
      if (b) sent.push_back({1'b1, ia, idd});
      if (w_enable) seen.push_back({w_select, w_addr, w_select ? w_id : w_alu});
      n_checks++;
      if (q_count !== 3'(exp_q[c]) || alu_ready !== (exp_q[c] <= QDEPTH - 2)) begin
        n_fail++;
        $display("[TB] FAIL b2b_qcount cyc %0d: got q=%0d ready=%b, expected q=%0d", c, q_count, alu_ready, exp_q[c]);
      end
    end
    for (int c = 0; c < 12 && (exp_en || waitq.size() > 0); c++) begin
      idle();
      if (w_enable) seen.push_back({w_select, w_addr, w_select ? w_id : w_alu});
    end
    n_checks++;
    if (seen.size() != sent.size() || sent.size() != 6) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d writes for %0d accepted, expected 6 each", seen.size(), sent.size());
    end else begin
      foreach (sent[i]) begin
        n_checks++;
        if (seen[i] !== sent[i]) begin
          n_fail++;
          $display("[TB] FAIL b2b_order #%0d: got %h expected %h", i, seen[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic a, b;
    int hits = 0;
    for (int c = 0; c < 3; c++)
      tick(1, 3'($urandom), 32'hA000_0000 | $urandom, 1, 3'($urandom), 32'hA000_0000 | $urandom, a, b);
    n_checks++;
    if (alu_ready !== 1'b0 || q_count !== 3'd3) begin
      n_fail++;
      $display("[TB] FAIL bp_full: got ready=%b q=%0d, expected 0 3", alu_ready, q_count);
    end
    tick(1, 3'd5, 32'h55, 0, 3'd0, 32'h0, a, b);
    if (w_enable && !w_select && w_addr == 3'd5 && w_alu == 32'h55) hits++;
    n_checks++;
    if (alu_ready !== 1'b1 || q_count !== 3'(waitq.size()) || a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: got ready=%b q=%0d, expected 1 %0d", alu_ready, q_count, waitq.size());
    end
    tick(1, 3'd5, 32'h55, 0, 3'd0, 32'h0, a, b);
    if (w_enable && !w_select && w_addr == 3'd5 && w_alu == 32'h55) hits++;
    for (int c = 0; c < 10 && (exp_en || waitq.size() > 0); c++) begin
      idle();
      if (w_enable && !w_select && w_addr == 3'd5 && w_alu == 32'h55) hits++;
      n_checks++;
      if ({w_enable, w_select, w_addr, w_alu, w_id} !== {exp_en, exp_sel, exp_addr, exp_alu, exp_id}) begin
        n_fail++;
        $display("[TB] FAIL bp_drain cyc %0d: got %b %b %0d %h %h expected %b %b %0d %h %h", c,
                 w_enable, w_select, w_addr, w_alu, w_id, exp_en, exp_sel, exp_addr, exp_alu, exp_id);
      end
    end
    n_checks++;
    if (hits != 1) begin
      n_fail++;
      $display("[TB] FAIL bp_once: got %0d issues of held result, expected 1", hits);
    end
  endtask

  task automatic test_reset_mid();
    logic a, b;
    for (int c = 0; c < 3; c++)
      tick(1, 3'($urandom), $urandom, 1, 3'($urandom), $urandom, a, b);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({w_enable, w_select, w_addr, w_alu, w_id, pending, q_count} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got en=%b sel=%b addr=%0d alu=%h id=%h pend=%b q=%0d, expected all zero",
               w_enable, w_select, w_addr, w_alu, w_id, pending, q_count);
    end
    rst_n = 1;
    model_reset();
    tick(1, 3'd2, 32'h11, 0, 3'd0, 32'h0, a, b);
    n_checks++;
    if ({w_enable, w_select, w_addr, w_alu, w_id} !== {1'b1, 1'b0, 3'd2, 32'h11, 32'h0} || q_count !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_next: got en=%b sel=%b addr=%0d alu=%h id=%h q=%0d, expected 1 0 2 11 0 0",
               w_enable, w_select, w_addr, w_alu, w_id, q_count);
    end
    idle();
    n_checks++;
    if (pending !== 8'h00 || w_enable !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_drain: got pend=%b en=%b, expected 0 0", pending, w_enable);
    end
  endtask

  task automatic test_pointer_wrap();
    logic a, b, av, iv;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) begin
        av = (c % 5 == 4) || (c % 2 == 0);
        iv = (c % 5 == 4) || (c % 2 == 1);
        tick(av, 3'($urandom), $urandom, iv, 3'($urandom), $urandom, a, b);
      end else begin
        idle();
      end
      n_checks++;
      if ({w_enable, w_select, w_addr, w_alu, w_id} !== {exp_en, exp_sel, exp_addr, exp_alu, exp_id}) begin
        n_fail++;
        $display("[TB] FAIL wrap_write cyc %0d: got %b %b %0d %h %h expected %b %b %0d %h %h", c,
                 w_enable, w_select, w_addr, w_alu, w_id, exp_en, exp_sel, exp_addr, exp_alu, exp_id);
      end
      n_checks++;
      if (q_count !== 3'(waitq.size()) || pending !== exp_pend() || id_ready !== model_ready()) begin
        n_fail++;
        $display("[TB] FAIL wrap_state cyc %0d: got q=%0d pend=%b ready=%b expected q=%0d pend=%b ready=%b", c,
                 q_count, pending, id_ready, waitq.size(), exp_pend(), model_ready());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_same_cycle();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_pointer_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
